// File: rtl/ldf_scroll_mux.sv
// rtl/ldf_scroll_mux.sv - scanned 7-segment letter display with a scrolling message buffer
// Optional BLINK_EN adds a blink input that blanks all digits on alternate 8-tick phases.
module ldf_scroll_mux #(
   parameter int N_DIGITS    = 4,
   parameter int MSG_DEPTH   = 16,
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 25000000
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef BLINK_EN
   input  logic                         blink,
`endif
   input  logic                         wr_en,
   input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
   input  logic [4:0]                   wr_data,
   input  logic [$clog2(MSG_DEPTH):0]   msg_len,
   input  logic                         scroll_en,
   output logic [N_DIGITS-1:0]          an,
   output logic [0:6]                   disp,
   output logic                         scroll_tick
);

   localparam int AW = $clog2(MSG_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int SW = $clog2(SCROLL_DIV);

   logic [4:0]          mem [MSG_DEPTH];
   logic [RW-1:0]       rcnt;
   logic [SW-1:0]       scnt;
   logic [DW-1:0]       dig;
   logic [AW-1:0]       offset;
   logic                pend;
   logic                go;
   logic [N_DIGITS-1:0] an_q;

   logic                rwrap;
   logic                swrap;
   logic                dwrap;
   logic                len_ok;
   logic                off_big;
   logic                can_scroll;
   logic                in_msg;
   logic [AW-1:0]       eff_off;
   logic [LW:0]         sum;
   logic [LW:0]         idx_full;
   logic [4:0]          code;

   function automatic logic [6:0] glyph(input logic [4:0] c);
      case (c)
         5'd0:    glyph = 7'h77;
         5'd1:    glyph = 7'h1F;
         5'd2:    glyph = 7'h58;
         5'd3:    glyph = 7'h3D;
         5'd4:    glyph = 7'h4F;
         5'd5:    glyph = 7'h47;
         5'd6:    glyph = 7'h5E;
         5'd7:    glyph = 7'h37;
         5'd8:    glyph = 7'h3C;
         5'd9:    glyph = 7'h0E;
         5'd10:   glyph = 7'h15;
         5'd11:   glyph = 7'h1D;
         5'd12:   glyph = 7'h67;
         5'd13:   glyph = 7'h05;
         5'd14:   glyph = 7'h5B;
         5'd15:   glyph = 7'h3B;
         5'd31:   glyph = 7'h00;
         default: glyph = 7'h7F;
      endcase
   endfunction

   assign rwrap      = 32'(rcnt) == REFRESH_DIV - 1;
   assign swrap      = 32'(scnt) == SCROLL_DIV - 1;
   assign dwrap      = 32'(dig) == N_DIGITS - 1;
   assign len_ok     = (msg_len != '0) && (32'(msg_len) <= MSG_DEPTH);
   assign off_big    = LW'(offset) >= msg_len;
   assign can_scroll = scroll_en && (32'(msg_len) > N_DIGITS) && (32'(msg_len) <= MSG_DEPTH);

   // Both terms are below msg_len when the digit is inside the message, so one subtract wraps it.
   assign eff_off  = off_big ? '0 : offset;
   assign sum      = (LW+1)'(eff_off) + (LW+1)'(dig);
   assign in_msg   = (LW+1)'(dig) < {1'b0, msg_len};
   assign idx_full = (sum >= {1'b0, msg_len}) ? sum - {1'b0, msg_len} : sum;
   assign code     = (len_ok && in_msg) ? mem[idx_full[AW-1:0]] : 5'd31;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MSG_DEPTH; k++) mem[k] <= 5'd31;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt        <= '0;
         scnt        <= '0;
         dig         <= '0;
         offset      <= '0;
         scroll_tick <= 1'b0;
      end else begin
         rcnt        <= rwrap ? '0 : rcnt + 1'b1;
         scnt        <= swrap ? '0 : scnt + 1'b1;
         scroll_tick <= swrap;
         if (rwrap) dig <= dwrap ? '0 : dig + 1'b1;
         if (off_big) begin
            offset <= '0;
         end else if (swrap && can_scroll) begin
            offset <= (LW'(offset) + 1'b1 >= msg_len) ? '0 : offset + 1'b1;
         end
      end
   end

   // Slot pipeline: one blank cycle after the index moves, then enable and latch segments together.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 1'b1;
         go   <= 1'b0;
         an_q <= '1;
         disp <= 7'h00;
      end else begin
         pend <= rwrap;
         go   <= pend;
         if (pend) begin
            an_q <= '1;
         end else if (go) begin
            an_q <= ~(N_DIGITS'(1) << (DW'(N_DIGITS - 1) - dig));
            disp <= glyph(code);
         end
      end
   end

`ifdef BLINK_EN
   logic [2:0] tcnt;
   logic       phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt  <= '0;
         phase <= 1'b0;
      end else if (swrap) begin
         tcnt <= tcnt + 1'b1;
         if (tcnt == 3'd7) phase <= ~phase;
      end
   end

   assign an = (blink && phase) ? '1 : an_q;
`else
   assign an = an_q;
`endif

endmodule

// File: tb/tb_ldf_scroll_mux.sv
// tb/tb_ldf_scroll_mux.sv - randomized self-checking bench for ldf_scroll_mux
module tb_ldf_scroll_mux;

   localparam int ND = 4;
   localparam int MD = 8;
   localparam int RD = 4;
   localparam int SD = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [4:0] wr_data = '0;
   logic [3:0] msg_len = '0;
   logic       scroll_en = 1'b0;
   logic [3:0] an;
   logic [0:6] disp;
   logic       scroll_tick;

   int total = 0;
   int bad = 0;

   int mbuf [MD];
   int moff = 0;
   int cnt = 0;
   int ticks = 0;

   logic [6:0] gtab [16] = '{7'h77, 7'h1F, 7'h58, 7'h3D, 7'h4F, 7'h47, 7'h5E, 7'h37,
                             7'h3C, 7'h0E, 7'h15, 7'h1D, 7'h67, 7'h05, 7'h5B, 7'h3B};

   always #5 clk = ~clk;

   ldf_scroll_mux #(.N_DIGITS(ND), .MSG_DEPTH(MD), .REFRESH_DIV(RD), .SCROLL_DIV(SD)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .scroll_en(scroll_en), .an(an), .disp(disp), .scroll_tick(scroll_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] glyph_of(input int c);
      if (c == 31) return 7'h00;
      if (c >= 16) return 7'h7F;
      return gtab[c];
   endfunction

   function automatic logic [6:0] expect_digit(input int i);
      int len;
      len = int'(msg_len);
      if (len == 0 || len > MD || i >= len) return 7'h00;
      return glyph_of(mbuf[(moff + i) % len]);
   endfunction

   // Reference state: window offset and tick phase from the cycle count since reset.
   always @(posedge clk) begin
      if (rst) begin
         cnt = 0;
         moff = 0;
         foreach (mbuf[k]) mbuf[k] = 31;
      end else begin
         cnt++;
         if (wr_en) mbuf[wr_addr] = int'(wr_data);
         if (moff >= int'(msg_len)) moff = 0;
         else if (cnt % SD == 0 && scroll_en && msg_len > ND && msg_len <= MD)
            moff = (moff + 1) % int'(msg_len);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (scroll_tick) ticks++;
         if (scroll_tick || (cnt > 0 && cnt % SD == 0))
            chk("tick", scroll_tick, (cnt > 0 && cnt % SD == 0));
      end
   end

   task automatic wr(input int a, input int d);
      wr_addr = 3'(a);
      wr_data = 5'(d);
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic check_window(input string tag);
      int guard, seen, direct, zeros, pos, i;
      logic [3:0] prev;
      repeat (20) @(negedge clk);
      guard = 0;
      while (cnt % SD != 8 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_sync"}, guard < 200, 1);
      seen = 0;
      direct = 0;
      prev = 4'hF;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         zeros = $countones(~an);
         chk({tag, "_onehot"}, zeros <= 1, 1);
         if (zeros == 1) begin
            pos = 0;
            for (int b = 0; b < ND; b++) if (!an[b]) pos = b;
            i = ND - 1 - pos;
            chk($sformatf("%s_d%0d", tag, i), disp, expect_digit(i));
            seen |= 1 << i;
            if ($countones(~prev) == 1 && prev != an) direct++;
         end
         prev = an;
      end
      chk({tag, "_seen"}, seen, 15);
      chk({tag, "_gap"}, direct, 0);
   endtask

   task automatic wait_an(input string tag, input logic [3:0] target, input logic [6:0] exp_disp);
      int guard;
      guard = 0;
      while (an !== target && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_found"}, guard < 100, 1);
      chk(tag, disp, exp_disp);
   endtask

   initial begin
      int guard, t0;
      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'b1111);
      chk("rst_disp", disp, 7'h00);
      chk("rst_tick", scroll_tick, 0);
      rst = 1'b0;
      check_window("blank");

      for (int a = 0; a < 4; a++) wr(a, a);
      msg_len = 4'd4;
      scroll_en = 1'b1;
      repeat (20) @(negedge clk);
      wait_an("st0", 4'b0111, 7'h77);
      wait_an("st1", 4'b1011, 7'h1F);
      wait_an("st2", 4'b1101, 7'h58);
      wait_an("st3", 4'b1110, 7'h3D);
      repeat (2 * SD) @(negedge clk);
      check_window("static");

      for (int a = 4; a < 6; a++) wr(a, a);
      msg_len = 4'd6;
      check_window("scroll");
      guard = 0;
      while (moff != 5 && guard < 8 * SD) begin
         @(negedge clk);
         guard++;
      end
      chk("reach5", moff, 5);
      repeat (20) @(negedge clk);
      wait_an("win5_0", 4'b0111, 7'h47);
      wait_an("win5_1", 4'b1011, 7'h77);
      msg_len = 4'd3;
      check_window("shrink");

      scroll_en = 1'b0;
      msg_len = 4'd6;
      t0 = ticks;
      repeat (4 * SD) @(negedge clk);
      chk("frozen_ticks", ticks - t0, 4);
      check_window("frozen");

      wr(1, 20);
      wr(2, 31);
      msg_len = 4'd4;
      repeat (20) @(negedge clk);
      wait_an("invalid", 4'b1011, 7'h7F);
      wait_an("blank31", 4'b1101, 7'h00);

      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < MD; a++) wr(a, $urandom_range(0, 31));
         msg_len = 4'($urandom_range(0, 10));
         scroll_en = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 150)) @(negedge clk);
         check_window($sformatf("rand%0d", it));
      end

      msg_len = 4'd4;
      guard = 0;
      while (an !== 4'b1101 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("mid_found", guard < 100, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_an", an, 4'b1111);
      chk("mid_disp", disp, 7'h00);
      rst = 1'b0;
      check_window("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
